// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotator.
// K_INV is only consumed when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

    localparam int ITER_MAX = 16;
    localparam int IW       = 18;
    localparam logic signed [15:0] K_INV = 16'sh26DD;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        COMP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Clamp a wide signed value into the signed 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/cordic_constants.sv
// Combinational arctangent ROM: alpha_i = round(atan(2^-i) * 2^14), Q1.14 radians.
module cordic_constants (
    input  logic [3:0]  addr,
    output logic [15:0] alpha
);

    always_comb begin
        case (addr)
            4'd0:    alpha = 16'h3244;
            4'd1:    alpha = 16'h1DAC;
            4'd2:    alpha = 16'h0FAE;
            4'd3:    alpha = 16'h07F5;
            4'd4:    alpha = 16'h03FF;
            4'd5:    alpha = 16'h0200;
            4'd6:    alpha = 16'h0100;
            4'd7:    alpha = 16'h0080;
            4'd8:    alpha = 16'h0040;
            4'd9:    alpha = 16'h0020;
            4'd10:   alpha = 16'h0010;
            4'd11:   alpha = 16'h0008;
            4'd12:   alpha = 16'h0004;
            4'd13:   alpha = 16'h0002;
            4'd14:   alpha = 16'h0001;
            default: alpha = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, saturated Q1.14 outputs.
// Optional gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_res
);

    localparam int CW = $clog2(ITER_MAX);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t state_reg, state_next;
    logic   in_ready_reg, in_ready_next;
    logic   out_valid_reg, out_valid_next;

    logic [CW-1:0]           iter_reg;
    logic signed [IW-1:0]    xy_reg  [2];
    logic signed [IW-1:0]    xy_next [2];
    logic [WIDTH-1:0]        sat_val [2];
    logic [WIDTH-1:0]        res_reg [2];
    logic signed [WIDTH-1:0] z_reg, z_next;
    logic [WIDTH-1:0]        zres_reg;
    logic [WIDTH-1:0]        alpha;
    logic                    d_neg, accept, last_iter;

    cordic_constants u_rom (
        .addr  (iter_reg),
        .alpha (alpha)
    );

    assign accept    = in_valid && in_ready_reg;
    assign last_iter = (iter_reg == LAST);
    assign d_neg     = z_reg[WIDTH-1];
    assign z_next    = d_neg ? (z_reg + $signed(alpha)) : (z_reg - $signed(alpha));

    // Lane 0 is x (subtracts d*y>>>i), lane 1 is y (adds d*x>>>i).
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [IW-1:0] shifted;
        logic                 add_sel;

        assign shifted     = xy_reg[1-gi] >>> iter_reg;
        assign add_sel     = (gi == 1) ? !d_neg : d_neg;
        assign xy_next[gi] = add_sel ? (xy_reg[gi] + shifted) : (xy_reg[gi] - shifted);

`ifdef CORDIC_GAIN_COMP_EN
        logic signed [IW+WIDTH-1:0] prod;

        assign prod        = xy_reg[gi] * K_INV;
        assign sat_val[gi] = sat16(32'(prod >>> 14));
`else
        assign sat_val[gi] = sat16(32'(xy_next[gi]));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ROTATE;
                end
            end
            ROTATE: begin
                if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = COMP;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                state_next = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

    // Output registers are written only when the result is finalised, so they hold through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xy_reg   <= '{default: '0};
            res_reg  <= '{default: '0};
            z_reg    <= '0;
            zres_reg <= '0;
            iter_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        xy_reg[0] <= {{(IW-WIDTH){x_in[WIDTH-1]}}, x_in};
                        xy_reg[1] <= {{(IW-WIDTH){y_in[WIDTH-1]}}, y_in};
                        z_reg     <= z_in;
                        iter_reg  <= '0;
                    end
                end
                ROTATE: begin
                    xy_reg   <= xy_next;
                    z_reg    <= z_next;
                    iter_reg <= iter_reg + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
                    if (last_iter) begin
                        res_reg  <= sat_val;
                        zres_reg <= z_next;
                    end
`endif
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    res_reg  <= sat_val;
                    zres_reg <= z_reg;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign x_out     = res_reg[0];
    assign y_out     = res_reg[1];
    assign z_res     = zres_reg;

endmodule

// File: doc/cordic_rotator.md
# cordic_rotator

Iterative rotation-mode CORDIC engine that consumes the arctangent constant ROM `cordic_constants`. It accepts a vector (x, y) and a target angle z, and performs one micro-rotation per clock, indexing the ROM with its iteration counter. It then returns the rotated vector. It sits directly downstream of the ROM and upstream of any sin/cos or vector-rotation consumer.

## Interface
- `WIDTH`, 16: data and angle width; fixed to match ROM output.
- `ITER`, 16: number of micro-rotations, legal range 1..16 (ROM index is 4 bits).
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: input operands valid.
- `in_ready`  out  1: core can accept operands.
- `x_in`  in  16: signed Q1.14 x.
- `y_in`  in  16: signed Q1.14 y.
- `z_in`  in  16: signed Q1.14 angle, radians, legal range ±π/2 (±0x6488).
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts result.
- `x_out`  out  16: signed Q1.14 rotated x, saturated.
- `y_out`  out  16: signed Q1.14 rotated y, saturated.
- `z_res`  out  16: residual angle after the last iteration.

## Operation
- **FSM states:** IDLE, ROTATE, COMP (only with the macro), DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, load x, y, z and i=0, then go to ROTATE.
- **ROTATE:** one iteration per cycle using alpha_i from the ROM at index i.
  - d=+1 if z[MSB]==0, else d=−1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·alpha_i
  - After i==ITER−1, go to COMP if the macro is defined, otherwise to DONE.
- **Arithmetic:**
  - x and y are held internally as 18-bit signed values (Q3.14); sign-extend on load.
  - `>>>` is an arithmetic shift with truncation.
  - z is held as 16 bits; z wraps two's-complement, which cannot occur for legal inputs.
- **Output conversion:** on entry to DONE, x and y saturate to 16 bits (0x7FFF / 0x8000). `z_res` is registered with them.
- **DONE:**
  - `out_valid`=1.
  - Outputs stay stable until `out_valid`&&`out_ready`, then return to IDLE.
- **Input gating:** `in_ready`=0 in every state except IDLE. `in_valid` outside IDLE is ignored; there is no overlap of transactions.
- **Reset values:** all outputs are 0 on reset (`in_ready` is 0 while `rst` is high, 1 on the first cycle after release). State is IDLE, i=0.
- **Reset mid-operation:** reset asserted in any state aborts immediately. No result is produced.

## Timing
- Accept edge = cycle 0.
- ROTATE occupies cycles 1..ITER.
- `out_valid` rises at cycle ITER+1 (17 by default), or ITER+2 with COMP.
- If `out_ready` is already high, the result is consumed in that same cycle.
- IDLE, with `in_ready`=1, follows on the next cycle.
- Minimum throughput: one result per ITER+2 cycles (+1 with COMP).
- The ROM is combinational; alpha_i is used in the same cycle i is presented.

## Configuration
- **Macro:** `CORDIC_GAIN_COMP_EN`.
- **Defined:**
  - The COMP state performs one cycle of 18×16 signed multiply of x and y by K_INV = 0x26DD (0.607253, Q1.14).
  - The product is shifted right by 14 with truncation, then saturated.
  - Result magnitude equals the input magnitude.
- **Undefined:**
  - The COMP state is absent.
  - Outputs carry the CORDIC gain K≈1.6468 (for ITER=16).

## Structure
- **Package `cordic_pkg`:**
  - state enum
  - `K_INV` constant
  - `ITER_MAX`=16
  - internal width `IW`=18
  - saturation helper function
- **Sub-module:** instantiate the existing `cordic_constants` ROM, index = iteration counter. No other sub-modules.

## Test plan
Tolerance ±4 LSB unless stated.

1. **45° rotation:** x=0x4000, y=0, z=0x3244, macro off.
   - x_out≈y_out≈0x4A86.
   - out_valid at cycle 17 after accept.
   - Macro on: x_out≈y_out≈0x2D41, out_valid at cycle 18.
2. **Zero angle:** x=0x4000, y=0, z=0.
   - Macro off: x_out≈0x6965, y_out≈0.
   - Macro on: x_out≈0x4000.
   - z_res within ±2 LSB of 0.
3. **−90° rotation:** x=0x4000, y=0, z=0x9B78.
   - Macro off: x_out≈0, y_out≈0x969B.
4. **Saturation:** x=y=0x7FFF, z=0, macro off.
   - x_out=0x7FFF, y_out=0x7FFF (no wrap).
5. **Back-pressure:** hold out_ready=0 for 10 cycles after out_valid, with in_valid high throughout.
   - Outputs stable.
   - in_ready=0.
   - No second accept until one cycle after the out_ready handshake.
6. **Reset mid-operation:** assert rst at ROTATE iteration 7.
   - Immediately: out_valid=0, outputs=0.
   - in_ready=1 the cycle after release.
   - Follow-up scenario 1 transaction produces the correct result.
